// File: rtl/wt_pkg.sv
// Shared types, defaults and the pitch-scale table for the wavetable voice scheduler.
package wt_pkg;

   localparam int NUM_VOICES_DEF = 4;
   localparam int POS_W_DEF      = 13;
   localparam int SAMPLE_W_DEF   = 16;
   localparam int TIMEOUT_DEF    = 64;
   localparam int VOICE_W_DEF    = $clog2(NUM_VOICES_DEF);
   localparam int NUM_KEYS       = 13;
   localparam int KEY_W          = 4;
   localparam int WAVE_W         = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SCAN,
      ST_ISSUE,
      ST_WAIT,
      ST_ACC,
      ST_MIX
   } sched_state_t;

   // Per-frame position increment for each note A..A'.
   function automatic logic [7:0] scale_of(input logic [KEY_W-1:0] key);
      logic [7:0] s;
      case (key)
         4'd0:    s = 8'd74;
         4'd1:    s = 8'd78;
         4'd2:    s = 8'd83;
         4'd3:    s = 8'd88;
         4'd4:    s = 8'd93;
         4'd5:    s = 8'd99;
         4'd6:    s = 8'd104;
         4'd7:    s = 8'd111;
         4'd8:    s = 8'd117;
         4'd9:    s = 8'd124;
         4'd10:   s = 8'd132;
         4'd11:   s = 8'd139;
         4'd12:   s = 8'd148;
         default: s = 8'd0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/wt_voice_alloc.sv
// Voice slot table: note_on/note_off allocation, voice stealing and per-slot position storage.
module wt_voice_alloc
   import wt_pkg::*;
#(
   parameter int  NUM_VOICES = NUM_VOICES_DEF,
   parameter int  POS_W      = POS_W_DEF,
   localparam int VOICE_W    = $clog2(NUM_VOICES)
) (
   input  logic                  clk_50,
   input  logic                  ar,
   input  logic                  note_on,
   input  logic                  note_off,
   input  logic [KEY_W-1:0]      key_val,
   input  logic [WAVE_W-1:0]     wave_sel,
   input  logic [VOICE_W-1:0]    rd_idx,
   output logic [POS_W-1:0]      rd_pos,
   output logic [KEY_W-1:0]      rd_key,
   output logic [WAVE_W-1:0]     rd_wave,
   input  logic                  pos_we,
   input  logic [POS_W-1:0]      pos_wdata,
   output logic [NUM_VOICES-1:0] active,
   output logic [NUM_VOICES-1:0] touched
);

   logic [NUM_VOICES-1:0] active_reg;
   logic [KEY_W-1:0]      key_reg  [NUM_VOICES];
   logic [WAVE_W-1:0]     wave_reg [NUM_VOICES];
   logic [POS_W-1:0]      pos_reg  [NUM_VOICES];
   logic [VOICE_W-1:0]    steal_reg, steal_next;

   logic [NUM_VOICES-1:0] match, clear_vec, start_vec, act_off;
   logic                  do_on, do_off;

   for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_match
      assign match[gi] = active_reg[gi] && (key_reg[gi] == key_val);
   end

   // Note-off is applied before note-on so a same-cycle on+off restarts the voice.
   always_comb begin
      do_on      = note_on  && (key_val < KEY_W'(NUM_KEYS));
      do_off     = note_off && (key_val < KEY_W'(NUM_KEYS));
      clear_vec  = do_off ? match : '0;
      act_off    = active_reg & ~clear_vec;
      start_vec  = '0;
      steal_next = steal_reg;
      if (do_on) begin
         if (|(act_off & match)) begin
            start_vec = act_off & match;
         end else if (!(&act_off)) begin
            for (int i = NUM_VOICES - 1; i >= 0; i--) begin
               if (!act_off[i]) begin
                  start_vec    = '0;
                  start_vec[i] = 1'b1;
               end
            end
         end else begin
            start_vec[steal_reg] = 1'b1;
            steal_next           = steal_reg + VOICE_W'(1);
         end
      end
      touched = clear_vec | start_vec;
   end

   // Slot table update; a (re)start overrides any scheduler position write to the same slot.
   always_ff @(posedge clk_50) begin
      if (ar) begin
         active_reg <= '0;
         steal_reg  <= '0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            key_reg[i]  <= '0;
            wave_reg[i] <= '0;
            pos_reg[i]  <= '0;
         end
      end else begin
         steal_reg <= steal_next;
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (start_vec[i]) begin
               active_reg[i] <= 1'b1;
               key_reg[i]    <= key_val;
               wave_reg[i]   <= wave_sel;
               pos_reg[i]    <= '0;
            end else begin
               if (clear_vec[i]) active_reg[i] <= 1'b0;
               if (pos_we && (rd_idx == VOICE_W'(i))) pos_reg[i] <= pos_wdata;
            end
         end
      end
   end

   assign rd_pos  = pos_reg[rd_idx];
   assign rd_key  = key_reg[rd_idx];
   assign rd_wave = wave_reg[rd_idx];
   assign active  = active_reg;

endmodule

// File: rtl/wt_voice_sched.sv
// Per-frame polyphonic read scheduler: one memory read per active voice, then an averaged mix.
module wt_voice_sched
   import wt_pkg::*;
#(
   parameter int  NUM_VOICES = NUM_VOICES_DEF,
   parameter int  POS_W      = POS_W_DEF,
   parameter int  SAMPLE_W   = SAMPLE_W_DEF,
   parameter int  TIMEOUT    = TIMEOUT_DEF,
   localparam int VOICE_W    = $clog2(NUM_VOICES),
   localparam int ACC_W      = SAMPLE_W + VOICE_W,
   localparam int TMR_W      = $clog2(TIMEOUT)
) (
   input  logic                    clk_50,
   input  logic                    ar,
   input  logic                    daclrck,
   input  logic                    note_on,
   input  logic                    note_off,
   input  logic [KEY_W-1:0]        key_val,
   input  logic [WAVE_W-1:0]       wave_sel,
   output logic [WAVE_W+POS_W-1:0] mem_addr,
   output logic                    mem_rd,
   input  logic [SAMPLE_W-1:0]     mem_dout,
   input  logic                    mem_done,
   output logic [SAMPLE_W-1:0]     mix_out,
   output logic                    mix_valid,
   output logic [NUM_VOICES-1:0]   voice_active,
   output logic                    frame_overrun,
   output logic                    mem_timeout
);

   sched_state_t               state_reg, state_next;
   logic [2:0]                 sync_reg;
   logic                       frame_edge;
   logic [VOICE_W-1:0]         cur_v_reg, cur_v_next;
   logic [VOICE_W:0]           scan_ptr_reg, scan_ptr_next;
   logic [TMR_W-1:0]           wait_cnt_reg, wait_cnt_next;
   logic [SAMPLE_W-1:0]        sample_reg, sample_next;
   logic signed [ACC_W-1:0]    acc_reg, acc_next, acc_shr;
   logic [WAVE_W+POS_W-1:0]    addr_hold_reg, addr_hold_next;
   logic                       dirty_reg, dirty_next;
   logic [SAMPLE_W-1:0]        mix_out_reg, mix_out_next;
   logic                       mix_valid_reg, mix_valid_next;
   logic                       overrun_reg, overrun_next;
   logic                       timeout_reg, timeout_next;
   logic                       scan_found;
   logic [VOICE_W-1:0]         scan_idx;
   logic [POS_W-1:0]           rd_pos, pos_wdata;
   logic [KEY_W-1:0]           rd_key;
   logic [WAVE_W-1:0]          rd_wave;
   logic                       pos_we;
   logic [NUM_VOICES-1:0]      touched;

   wt_voice_alloc #(
      .NUM_VOICES (NUM_VOICES),
      .POS_W      (POS_W)
   ) u_alloc (
      .clk_50    (clk_50),
      .ar        (ar),
      .note_on   (note_on),
      .note_off  (note_off),
      .key_val   (key_val),
      .wave_sel  (wave_sel),
      .rd_idx    (cur_v_reg),
      .rd_pos    (rd_pos),
      .rd_key    (rd_key),
      .rd_wave   (rd_wave),
      .pos_we    (pos_we),
      .pos_wdata (pos_wdata),
      .active    (voice_active),
      .touched   (touched)
   );

   assign frame_edge = sync_reg[1] & ~sync_reg[2];
   assign acc_shr    = acc_reg >>> VOICE_W;
   assign pos_wdata  = rd_pos + POS_W'(scale_of(rd_key));

   // Next active slot at or above the scan pointer, using live flags so mid-frame edits take effect.
   always_comb begin
      scan_found = 1'b0;
      scan_idx   = '0;
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         if (voice_active[i] && (i >= int'(scan_ptr_reg))) begin
            scan_found = 1'b1;
            scan_idx   = VOICE_W'(i);
         end
      end
   end

   // Scheduler next-state and datapath control.
   always_comb begin
      state_next     = state_reg;
      cur_v_next     = cur_v_reg;
      scan_ptr_next  = scan_ptr_reg;
      wait_cnt_next  = wait_cnt_reg;
      sample_next    = sample_reg;
      acc_next       = acc_reg;
      addr_hold_next = addr_hold_reg;
      dirty_next     = dirty_reg;
      mix_out_next   = mix_out_reg;
      mix_valid_next = 1'b0;
      overrun_next   = overrun_reg;
      timeout_next   = timeout_reg;
      mem_rd         = 1'b0;
      pos_we         = 1'b0;
      if (frame_edge && (state_reg != ST_IDLE)) overrun_next = 1'b1;
      case (state_reg)
         ST_IDLE: begin
            if (frame_edge) begin
               scan_ptr_next = '0;
               state_next    = (|voice_active) ? ST_SCAN : ST_MIX;
            end
         end
         ST_SCAN: begin
            if (scan_found) begin
               cur_v_next    = scan_idx;
               scan_ptr_next = {1'b0, scan_idx} + (VOICE_W+1)'(1);
               dirty_next    = 1'b0;
               state_next    = ST_ISSUE;
            end else begin
               state_next = ST_MIX;
            end
         end
         ST_ISSUE: begin
            mem_rd         = 1'b1;
            addr_hold_next = {rd_wave, rd_pos};
            wait_cnt_next  = '0;
            if (touched[cur_v_reg]) dirty_next = 1'b1;
            state_next     = ST_WAIT;
         end
         ST_WAIT: begin
            if (touched[cur_v_reg]) dirty_next = 1'b1;
            if (mem_done) begin
               sample_next = {mem_dout[7:0], mem_dout[15:8]};
               state_next  = ST_ACC;
            end else if (wait_cnt_reg == TMR_W'(TIMEOUT - 1)) begin
               sample_next  = '0;
               timeout_next = 1'b1;
               state_next   = ST_ACC;
            end else begin
               wait_cnt_next = wait_cnt_reg + TMR_W'(1);
            end
         end
         ST_ACC: begin
            acc_next   = acc_reg + {{VOICE_W{sample_reg[SAMPLE_W-1]}}, sample_reg};
            // A slot restarted or released during its read keeps its new position.
            pos_we     = !dirty_reg && !touched[cur_v_reg];
            state_next = ST_SCAN;
         end
         ST_MIX: begin
            mix_out_next   = acc_shr[SAMPLE_W-1:0];
            mix_valid_next = 1'b1;
            acc_next       = '0;
            state_next     = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // State and datapath registers, plus the daclrck synchroniser / edge history.
   always_ff @(posedge clk_50) begin
      if (ar) begin
         state_reg     <= ST_IDLE;
         sync_reg      <= '0;
         cur_v_reg     <= '0;
         scan_ptr_reg  <= '0;
         wait_cnt_reg  <= '0;
         sample_reg    <= '0;
         acc_reg       <= '0;
         addr_hold_reg <= '0;
         dirty_reg     <= 1'b0;
         mix_out_reg   <= '0;
         mix_valid_reg <= 1'b0;
         overrun_reg   <= 1'b0;
         timeout_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         sync_reg      <= {sync_reg[1:0], daclrck};
         cur_v_reg     <= cur_v_next;
         scan_ptr_reg  <= scan_ptr_next;
         wait_cnt_reg  <= wait_cnt_next;
         sample_reg    <= sample_next;
         acc_reg       <= acc_next;
         addr_hold_reg <= addr_hold_next;
         dirty_reg     <= dirty_next;
         mix_out_reg   <= mix_out_next;
         mix_valid_reg <= mix_valid_next;
         overrun_reg   <= overrun_next;
         timeout_reg   <= timeout_next;
      end
   end

   assign mem_addr      = (state_reg == ST_ISSUE) ? {rd_wave, rd_pos} : addr_hold_reg;
   assign mix_out       = mix_out_reg;
   assign mix_valid     = mix_valid_reg;
   assign frame_overrun = overrun_reg;
   assign mem_timeout   = timeout_reg;

endmodule

// File: tb/tb_wt_voice_sched.sv
// Directed bench for wt_voice_sched: allocation table plus hand-written frame sequences.
module tb_wt_voice_sched;

   logic        clk_50 = 1'b0;
   logic        ar = 1'b1;
   logic        daclrck = 1'b0;
   logic        note_on = 1'b0;
   logic        note_off = 1'b0;
   logic [3:0]  key_val = '0;
   logic [1:0]  wave_sel = '0;
   logic [14:0] mem_addr;
   logic        mem_rd;
   logic [15:0] mem_dout = '0;
   logic        mem_done = 1'b0;
   logic [15:0] mix_out;
   logic        mix_valid;
   logic [3:0]  voice_active;
   logic        frame_overrun;
   logic        mem_timeout;

   int          total_cnt = 0;
   int          pass_cnt = 0;
   int          rd_cnt = 0;
   int          mix_cnt = 0;
   logic [15:0] last_mix = '0;
   logic [14:0] addr_q[$];
   int          mem_lat = 1;
   int          skip_n = 0;
   logic [15:0] mem_data = 16'h0010;

   typedef struct {
      logic       on;
      logic       off;
      logic [3:0] key;
      logic [1:0] wave;
      logic [3:0] exp_act;
   } vec_t;
   vec_t vecs[15];

   wt_voice_sched dut (
      .clk_50        (clk_50),
      .ar            (ar),
      .daclrck       (daclrck),
      .note_on       (note_on),
      .note_off      (note_off),
      .key_val       (key_val),
      .wave_sel      (wave_sel),
      .mem_addr      (mem_addr),
      .mem_rd        (mem_rd),
      .mem_dout      (mem_dout),
      .mem_done      (mem_done),
      .mix_out       (mix_out),
      .mix_valid     (mix_valid),
      .voice_active  (voice_active),
      .frame_overrun (frame_overrun),
      .mem_timeout   (mem_timeout)
   );

   always #10 clk_50 = ~clk_50;

   // Observe reads and mixes away from the active edge.
   always @(negedge clk_50) begin
      if (mem_rd) begin
         rd_cnt++;
         addr_q.push_back(mem_addr);
         $display("read  addr=%h", mem_addr);
      end
      if (mix_valid) begin
         mix_cnt++;
         last_mix = mix_out;
         $display("mix   out=%h", mix_out);
      end
   end

   // Memory model: answers each read after mem_lat half-cycle-aligned clocks unless told to skip.
   initial begin
      forever begin
         @(negedge clk_50);
         if (mem_rd) begin
            if (skip_n > 0) begin
               skip_n--;
            end else begin
               repeat (mem_lat) @(negedge clk_50);
               mem_dout = mem_data;
               mem_done = 1'b1;
               @(negedge clk_50);
               mem_done = 1'b0;
            end
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: got %h required %h", name, act, exp);
      else pass_cnt++;
   endtask

   task automatic chk_addr(input string name, input logic [14:0] exp);
      if (addr_q.size() == 0) chk(name, 32'hDEAD_BEEF, {17'd0, exp});
      else chk(name, {17'd0, addr_q.pop_front()}, {17'd0, exp});
   endtask

   task automatic do_reset();
      @(posedge clk_50);
      #1;
      daclrck  = 1'b0;
      note_on  = 1'b0;
      note_off = 1'b0;
      ar       = 1'b1;
      mem_lat  = 1;
      skip_n   = 0;
      repeat (3) @(posedge clk_50);
      #1;
      ar = 1'b0;
      repeat (2) @(posedge clk_50);
      addr_q.delete();
   endtask

   task automatic note(input logic on, input logic off, input logic [3:0] k, input logic [1:0] w);
      @(posedge clk_50);
      #1;
      note_on  = on;
      note_off = off;
      key_val  = k;
      wave_sel = w;
      @(posedge clk_50);
      #1;
      note_on  = 1'b0;
      note_off = 1'b0;
   endtask

   // One frame: raise daclrck, wait (bounded) for a mix pulse, lower daclrck.
   task automatic do_frame(input string tag);
      int c0;
      int n;
      c0 = mix_cnt;
      n  = 0;
      @(posedge clk_50);
      #1;
      daclrck = 1'b1;
      while (mix_cnt == c0 && n < 500) begin
         @(negedge clk_50);
         n++;
      end
      chk(tag, 32'(mix_cnt != c0), 32'd1);
      #1;
      daclrck = 1'b0;
      repeat (4) @(posedge clk_50);
   endtask

   initial begin
      int c0;
      int r0;
      int n;

      vecs[0]  = '{1'b1, 1'b0, 4'd0,  2'd0, 4'b0001};
      vecs[1]  = '{1'b1, 1'b0, 4'd3,  2'd1, 4'b0011};
      vecs[2]  = '{1'b1, 1'b0, 4'd7,  2'd2, 4'b0111};
      vecs[3]  = '{1'b1, 1'b0, 4'd12, 2'd3, 4'b1111};
      vecs[4]  = '{1'b1, 1'b0, 4'd5,  2'd0, 4'b1111};  // steals slot 0
      vecs[5]  = '{1'b0, 1'b1, 4'd0,  2'd0, 4'b1111};  // key 0 no longer held
      vecs[6]  = '{1'b0, 1'b1, 4'd5,  2'd0, 4'b1110};  // slot 0 held key 5
      vecs[7]  = '{1'b1, 1'b0, 4'd5,  2'd0, 4'b1111};  // lowest free slot 0
      vecs[8]  = '{1'b1, 1'b0, 4'd9,  2'd0, 4'b1111};  // steals slot 1
      vecs[9]  = '{1'b0, 1'b1, 4'd3,  2'd0, 4'b1111};  // key 3 was stolen
      vecs[10] = '{1'b0, 1'b1, 4'd9,  2'd0, 4'b1101};  // slot 1 held key 9
      vecs[11] = '{1'b1, 1'b0, 4'd13, 2'd0, 4'b1101};  // out-of-range key ignored
      vecs[12] = '{1'b0, 1'b1, 4'd14, 2'd0, 4'b1101};
      vecs[13] = '{1'b1, 1'b0, 4'd7,  2'd1, 4'b1101};  // retrigger in place
      vecs[14] = '{1'b0, 1'b1, 4'd12, 2'd0, 4'b0101};

      // Reset state
      repeat (3) @(posedge clk_50);
      #1;
      ar = 1'b0;
      @(negedge clk_50);
      chk("rst_mix_out", 32'(mix_out), 32'd0);
      chk("rst_mix_valid", 32'(mix_valid), 32'd0);
      chk("rst_active", 32'(voice_active), 32'd0);
      chk("rst_overrun", 32'(frame_overrun), 32'd0);
      chk("rst_timeout", 32'(mem_timeout), 32'd0);
      chk("rst_mem_rd", 32'(mem_rd), 32'd0);

      // No notes: three frames, three zero mixes, no reads
      c0 = mix_cnt;
      repeat (3) do_frame("idle_frame");
      chk("idle_mix_count", 32'(mix_cnt - c0), 32'd3);
      chk("idle_mix_out", 32'(last_mix), 32'd0);
      chk("idle_no_reads", 32'(rd_cnt), 32'd0);

      // Single voice, key 0 wave 1, byte-swapped sample averaged over four slots
      do_reset();
      mem_data = 16'h0010;
      note(1'b1, 1'b0, 4'd0, 2'd1);
      do_frame("v1_frame0");
      chk_addr("v1_addr0", 15'h2000);
      chk("v1_mix0", 32'(last_mix), 32'h0400);
      do_frame("v1_frame1");
      chk_addr("v1_addr1", 15'h204A);
      chk("v1_mix1", 32'(last_mix), 32'h0400);
      do_frame("v1_frame2");
      chk_addr("v1_addr2", 15'h2094);

      // Allocation table
      do_reset();
      for (int i = 0; i < 15; i++) begin
         note(vecs[i].on, vecs[i].off, vecs[i].key, vecs[i].wave);
         @(negedge clk_50);
         $display("alloc vec=%0d on=%0d off=%0d key=%0d active=%b", i, vecs[i].on, vecs[i].off,
                  vecs[i].key, voice_active);
         chk($sformatf("alloc_%0d", i), 32'(voice_active), 32'(vecs[i].exp_act));
      end

      // Read timeout on the first voice, second voice still read
      do_reset();
      note(1'b1, 1'b0, 4'd0, 2'd0);
      note(1'b1, 1'b0, 4'd3, 2'd2);
      mem_data = 16'h0010;
      skip_n   = 1;
      do_frame("to_frame");
      chk("to_flag", 32'(mem_timeout), 32'd1);
      chk_addr("to_addr0", 15'h0000);
      chk_addr("to_addr1", 15'h4000);
      chk("to_mix", 32'(last_mix), 32'h0400);

      // Frame edge while waiting on memory
      do_reset();
      note(1'b1, 1'b0, 4'd12, 2'd0);
      mem_lat = 20;
      c0 = mix_cnt;
      r0 = rd_cnt;
      n  = 0;
      @(posedge clk_50);
      #1;
      daclrck = 1'b1;
      while (rd_cnt == r0 && n < 100) begin
         @(negedge clk_50);
         n++;
      end
      chk("ovr_read_seen", 32'(rd_cnt - r0), 32'd1);
      daclrck = 1'b0;
      repeat (4) @(posedge clk_50);
      #1;
      daclrck = 1'b1;
      n = 0;
      while (mix_cnt == c0 && n < 200) begin
         @(negedge clk_50);
         n++;
      end
      repeat (30) @(negedge clk_50);
      chk("ovr_flag", 32'(frame_overrun), 32'd1);
      chk("ovr_one_mix", 32'(mix_cnt - c0), 32'd1);
      daclrck = 1'b0;

      // Key 12 position wraps modulo 8192
      do_reset();
      note(1'b1, 1'b0, 4'd12, 2'd0);
      for (int f = 0; f < 57; f++) do_frame("wrap_frame");
      chk("wrap_reads", 32'(addr_q.size()), 32'd57);
      if (addr_q.size() >= 57) begin
         chk("wrap_addr55", 32'(addr_q[55]), 32'h1FCC);
         chk("wrap_addr56", 32'(addr_q[56]), 32'h0060);
      end

      // Same-cycle on+off restarts at position 0; out-of-range key leaves slots alone
      do_reset();
      note(1'b1, 1'b0, 4'd2, 2'd3);
      do_frame("onoff_frame0");
      chk_addr("onoff_addr0", 15'h6000);
      note(1'b1, 1'b1, 4'd2, 2'd3);
      @(negedge clk_50);
      chk("onoff_active", 32'(voice_active), 32'b0001);
      do_frame("onoff_frame1");
      chk_addr("onoff_addr1", 15'h6000);
      note(1'b1, 1'b0, 4'd13, 2'd0);
      @(negedge clk_50);
      chk("key13_active", 32'(voice_active), 32'b0001);
      do_frame("key13_frame");
      chk_addr("key13_addr", 15'h6053);

      // Reset asserted while waiting on memory
      mem_lat = 30;
      c0 = mix_cnt;
      r0 = rd_cnt;
      n  = 0;
      @(posedge clk_50);
      #1;
      daclrck = 1'b1;
      while (rd_cnt == r0 && n < 100) begin
         @(negedge clk_50);
         n++;
      end
      chk("arw_read_seen", 32'(rd_cnt - r0), 32'd1);
      daclrck = 1'b0;
      repeat (2) @(posedge clk_50);
      #1;
      ar = 1'b1;
      @(posedge clk_50);
      #1;
      ar = 1'b0;
      @(negedge clk_50);
      chk("arw_mem_rd", 32'(mem_rd), 32'd0);
      chk("arw_active", 32'(voice_active), 32'd0);
      chk("arw_timeout", 32'(mem_timeout), 32'd0);
      repeat (60) @(negedge clk_50);
      chk("arw_no_mix", 32'(mix_cnt - c0), 32'd0);
      chk("arw_no_read", 32'(rd_cnt - r0), 32'd1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
